// File: rtl/regfile_2r1w_if.sv
// Register file access bundle: one write port,
// two read ports and the clear/busy handshake.
interface regfile_2r1w_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  clear_req;
  logic                  busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr_a, rd_addr_b,
    output clear_req,
    input  rd_data_a, rd_data_b, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr_a, rd_addr_b,
    input  clear_req,
    output rd_data_a, rd_data_b, busy
  );
endinterface

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with registered reads,
// write bypass and a one-register-per-cycle clear.
module regfile_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input logic           clk,
  input logic           rst,
  regfile_2r1w_if.slave bus
);
  localparam int ADDR_WIDTH =
    (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [0:0]            state;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] rd_a_q;
  logic [DATA_WIDTH-1:0] rd_b_q;
  logic [DATA_WIDTH-1:0] next_a;
  logic [DATA_WIDTH-1:0] next_b;
  logic                  wr_ok;
  logic                  a_ok;
  logic                  b_ok;

  assign wr_ok = bus.wr_en && !busy_q &&
                 (int'(bus.wr_addr) < NUM_REGS);
  assign a_ok  = int'(bus.rd_addr_a) < NUM_REGS;
  assign b_ok  = int'(bus.rd_addr_b) < NUM_REGS;

  assign bus.rd_data_a = rd_a_q;
  assign bus.rd_data_b = rd_b_q;
  assign bus.busy      = busy_q;

  // Read mux: out-of-range, clear slot, write bypass, array.
  always_comb begin
    next_a = '0;
    next_b = '0;
    if (!a_ok)
      next_a = '0;
    else if (busy_q && bus.rd_addr_a == counter)
      next_a = '0;
    else if (wr_ok && bus.rd_addr_a == bus.wr_addr)
      next_a = bus.wr_data;
    else
      next_a = mem[bus.rd_addr_a];
    if (!b_ok)
      next_b = '0;
    else if (busy_q && bus.rd_addr_b == counter)
      next_b = '0;
    else if (wr_ok && bus.rd_addr_b == bus.wr_addr)
      next_b = bus.wr_data;
    else
      next_b = mem[bus.rd_addr_b];
  end

  // Storage: clear sweep owns the array while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (busy_q) begin
      mem[counter] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= next_a;
      rd_b_q <= next_b;
    end
  end

  // Clear sequencer; clear_req is ignored once running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      counter <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            counter <= '0;
          end
        end
        CLEAR: begin
          if (counter == LAST) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench: 8-entry and 6-entry register
// files driven through their access interfaces.
module tb_regfile_2r1w;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cnt;

  regfile_2r1w_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) b8 ();
  regfile_2r1w_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) b6 ();

  regfile_2r1w #(.DATA_WIDTH(16), .NUM_REGS(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  regfile_2r1w #(.DATA_WIDTH(16), .NUM_REGS(6)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (b6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    b8.wr_en = 0; b8.wr_addr = 0; b8.wr_data = 0;
    b8.rd_addr_a = 0; b8.rd_addr_b = 0; b8.clear_req = 0;
    b6.wr_en = 0; b6.wr_addr = 0; b6.wr_data = 0;
    b6.rd_addr_a = 0; b6.rd_addr_b = 0; b6.clear_req = 0;

    // async reset, no clock edge yet
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_a", 32'(b8.rd_data_a), 0);
    chk("rst_rd_b", 32'(b8.rd_data_b), 0);
    chk("rst_busy", 32'(b8.busy), 0);
    chk("rst6_busy", 32'(b6.busy), 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b8.rd_addr_a = 3'(i);
      b8.rd_addr_b = 3'(7 - i);
      tick;
      chk("rst_read_a", 32'(b8.rd_data_a), 0);
      chk("rst_read_b", 32'(b8.rd_data_b), 0);
    end

    // write r3 then read on both ports
    b8.wr_en = 1; b8.wr_addr = 3; b8.wr_data = 16'h1234;
    tick;
    b8.wr_en = 0;
    b8.rd_addr_a = 3; b8.rd_addr_b = 3;
    tick;
    chk("wr_rd_a", 32'(b8.rd_data_a), 32'h1234);
    chk("wr_rd_b", 32'(b8.rd_data_b), 32'h1234);

    // bypass on r5
    b8.wr_en = 1; b8.wr_addr = 5; b8.wr_data = 16'h00AA;
    tick;
    b8.wr_data = 16'hBEEF;
    b8.rd_addr_a = 5; b8.rd_addr_b = 3;
    tick;
    chk("byp_a", 32'(b8.rd_data_a), 32'hBEEF);
    chk("byp_other_b", 32'(b8.rd_data_b), 32'h1234);
    b8.wr_en = 0;
    b8.rd_addr_b = 5;
    tick;
    chk("byp_stored", 32'(b8.rd_data_b), 32'hBEEF);

    // pre-edge read: old value while writing
    b8.wr_en = 1; b8.wr_addr = 4; b8.wr_data = 16'h4444;
    b8.rd_addr_a = 3;
    tick;
    b8.wr_en = 0;
    chk("indep_a", 32'(b8.rd_data_a), 32'h1234);

    // fill r0..r7
    for (int i = 0; i < 8; i++) begin
      b8.wr_en = 1;
      b8.wr_addr = 3'(i);
      b8.wr_data = 16'(32'h1111 * i + 1);
      tick;
    end
    b8.wr_en = 0;
    b8.rd_addr_a = 7; b8.rd_addr_b = 0;
    tick;
    chk("fill_r7", 32'(b8.rd_data_a), 32'h7778);
    chk("fill_r0", 32'(b8.rd_data_b), 32'h0001);

    // clear sequence
    b8.clear_req = 1;
    tick;
    b8.clear_req = 0;
    chk("clr_busy_rise", 32'(b8.busy), 1);
    b8.rd_addr_a = 0; b8.rd_addr_b = 7;
    b8.wr_en = 1; b8.wr_addr = 2; b8.wr_data = 16'hFFFF;
    cnt = 1;
    tick;
    b8.wr_en = 0;
    chk("clr_byp_zero", 32'(b8.rd_data_a), 0);
    chk("clr_other", 32'(b8.rd_data_b), 32'h7778);
    while (b8.busy && cnt < 40) begin
      cnt++;
      b8.clear_req = (cnt == 4);
      b8.wr_en = (cnt == 8);
      b8.wr_addr = 2;
      b8.wr_data = 16'hFFFF;
      tick;
    end
    b8.clear_req = 0;
    b8.wr_en = 0;
    chk("clr_busy_cycles", 32'(cnt), 8);
    for (int i = 0; i < 8; i++) begin
      b8.rd_addr_a = 3'(i);
      b8.rd_addr_b = 3'(i);
      tick;
      chk("clr_read_a", 32'(b8.rd_data_a), 0);
      chk("clr_read_b", 32'(b8.rd_data_b), 0);
    end

    // abort clear with reset
    b8.rd_addr_a = 6; b8.rd_addr_b = 1;
    b8.wr_en = 1; b8.wr_addr = 1; b8.wr_data = 16'hABCD;
    tick;
    b8.wr_addr = 6; b8.wr_data = 16'h6666;
    tick;
    b8.wr_en = 0;
    b8.clear_req = 1;
    tick;
    b8.clear_req = 0;
    chk("abort_busy", 32'(b8.busy), 1);
    chk("abort_r6", 32'(b8.rd_data_a), 32'h6666);
    chk("abort_r1", 32'(b8.rd_data_b), 32'hABCD);
    tick;
    tick;
    chk("abort_r1_clr", 32'(b8.rd_data_b), 0);
    rst = 1'b1;
    #1;
    chk("abort_busy0", 32'(b8.busy), 0);
    chk("abort_rd_a0", 32'(b8.rd_data_a), 0);
    tick;
    rst = 1'b0;
    tick;
    chk("abort_r6_zero", 32'(b8.rd_data_a), 0);
    chk("abort_r1_zero", 32'(b8.rd_data_b), 0);
    b8.wr_en = 1; b8.wr_addr = 1; b8.wr_data = 16'h0F0F;
    b8.rd_addr_a = 1;
    tick;
    b8.wr_en = 0;
    chk("abort_wr_byp", 32'(b8.rd_data_a), 32'h0F0F);
    tick;
    chk("abort_wr_rd", 32'(b8.rd_data_b), 32'h0F0F);
    chk("abort_idle", 32'(b8.busy), 0);

    // NUM_REGS=6 boundaries
    b6.wr_en = 1; b6.wr_addr = 5; b6.wr_data = 16'h0055;
    tick;
    b6.wr_addr = 7; b6.wr_data = 16'h7777;
    tick;
    b6.wr_addr = 6; b6.wr_data = 16'h6666;
    b6.rd_addr_a = 6; b6.rd_addr_b = 5;
    tick;
    b6.wr_en = 0;
    chk("b6_oob_byp", 32'(b6.rd_data_a), 0);
    chk("b6_r5", 32'(b6.rd_data_b), 32'h0055);
    for (int i = 0; i < 6; i++) begin
      b6.rd_addr_a = 3'(i);
      b6.rd_addr_b = 3'(7);
      tick;
      chk("b6_scan", 32'(b6.rd_data_a),
          (i == 5) ? 32'h0055 : 32'h0);
      chk("b6_rd7", 32'(b6.rd_data_b), 0);
    end
    b6.rd_addr_a = 6;
    tick;
    chk("b6_rd6", 32'(b6.rd_data_a), 0);

    // clear_req with write on the same edge
    b6.wr_en = 1; b6.wr_addr = 0; b6.wr_data = 16'h005A;
    b6.clear_req = 1;
    b6.rd_addr_a = 0; b6.rd_addr_b = 5;
    tick;
    b6.wr_en = 0;
    b6.clear_req = 0;
    chk("b6_wr_lands", 32'(b6.rd_data_a), 32'h005A);
    chk("b6_r5_pre", 32'(b6.rd_data_b), 32'h0055);
    chk("b6_busy", 32'(b6.busy), 1);
    cnt = 0;
    while (b6.busy && cnt < 40) begin
      cnt++;
      tick;
    end
    chk("b6_busy_cycles", 32'(cnt), 6);
    tick;
    chk("b6_r0_clr", 32'(b6.rd_data_a), 0);
    chk("b6_r5_clr", 32'(b6.rd_data_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the bit width of every register and data port.
REQ-002 Parameter NUM_REGS, default 8, SHALL set register count; legal range 2..256.
REQ-003 Derived constant ADDR_WIDTH SHALL equal ceil(log2(NUM_REGS)), minimum 1.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-006 wr_en  input  1  SHALL request a write this cycle.
REQ-007 wr_addr  input  ADDR_WIDTH  SHALL be the write register index.
REQ-008 wr_data  input  DATA_WIDTH  SHALL be the write data.
REQ-009 rd_addr_a  input  ADDR_WIDTH  SHALL be the read index for port A.
REQ-010 rd_addr_b  input  ADDR_WIDTH  SHALL be the read index for port B.
REQ-011 rd_data_a  output  DATA_WIDTH  SHALL be registered read data, port A.
REQ-012 rd_data_b  output  DATA_WIDTH  SHALL be registered read data, port B.
REQ-013 clear_req  input  1  SHALL request a sequential clear of all registers.
REQ-014 busy  output  1  SHALL be high, registered, while a clear sequence is running.

Function
REQ-015 Storage SHALL be NUM_REGS words of DATA_WIDTH bits; no register is hardwired.
REQ-016 Write accepted iff wr_en=1 and busy=0 at the edge; reg[wr_addr] <= wr_data.
REQ-017 Write with wr_addr >= NUM_REGS SHALL be dropped with no state change.
REQ-018 Write while busy=1 SHALL be dropped; no queuing, no error flag.
REQ-019 Each read port SHALL have 1-cycle latency: address sampled at edge N, data valid after edge N.
REQ-020 Read data SHALL be the pre-edge register contents, except bypass per REQ-021/REQ-027.
REQ-021 Bypass: accepted write to same address in same cycle -> that port captures wr_data.
REQ-022 Both ports SHALL read independently; same address on both ports -> identical data.
REQ-023 Read with address >= NUM_REGS SHALL capture zero.
REQ-024 FSM states IDLE and CLEAR; IDLE + clear_req=1 -> CLEAR, clear counter <= 0, busy <= 1.
REQ-025 In CLEAR, each edge SHALL zero reg[counter] and increment counter by 1.
REQ-026 CLEAR with counter = NUM_REGS-1 -> IDLE, busy <= 0, counter <= 0; sequence = exactly NUM_REGS edges.
REQ-027 Read in CLEAR at address = counter SHALL capture zero (clear bypass); other addresses read stored values.
REQ-028 clear_req while busy=1 SHALL be ignored; no restart, no extension.
REQ-029 In IDLE, clear_req=1 with an accepted write, same edge: the write SHALL complete, then clear begins next edge.
REQ-030 busy SHALL go high the edge after clear_req is sampled and low the edge after the last register is zeroed.
REQ-031 Consequently a write issued the cycle after clear_req SHALL be dropped.

Reset
REQ-032 rst=1 SHALL immediately, without clk, force all registers, rd_data_a, rd_data_b, busy and counter to 0 and FSM to IDLE.
REQ-033 rst asserted mid-clear SHALL abort the sequence; after release, state = IDLE, busy=0, all registers 0.
REQ-034 First edge with rst=0 SHALL operate normally; writes and clear_req accepted on that edge.

Verification
REQ-035 Reset: rst pulse, no clk -> rd_data_a=rd_data_b=0, busy=0; read all addresses -> 0.
REQ-036 Write/read: write 0x1234 to r3, next cycle rd_addr_a=3, rd_addr_b=3 -> both 0x1234 one cycle later.
REQ-037 Bypass: r5=0x00AA; same cycle wr r5=0xBEEF and rd_addr_a=5 -> rd_data_a=0xBEEF next cycle.
REQ-038 Clear: fill r0..r7 with 0x1111*i+1, pulse clear_req -> busy high exactly 8 cycles; wr r2=0xFFFF during busy dropped; all reads 0 after.
REQ-039 Abort: assert rst on 3rd clear cycle -> busy=0 immediately, all registers 0, next write/read to r1 works.
REQ-040 Boundary: NUM_REGS=6, write to addr 7 -> no change; read addr 6 -> 0; clear_req+write r0=0x5A same edge -> r0 write lands, then cleared.
